// File: rtl/arbitro_temporizador.sv
// Shared countdown timer arbitrated round-robin among three requesters.
// The winner owns the timer until it expires, when a one-cycle done is emitted.
// A winner that drops its request before expiry releases the timer with no done.
module arbitro_temporizador #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_1hz,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] dur0,
  input  logic [WIDTH-1:0] dur1,
  input  logic [WIDTH-1:0] dur2,
  output logic [2:0]       grant,
  output logic [2:0]       done,
  output logic             busy,
  output logic [WIDTH-1:0] remaining
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [1:0]       state;
  logic [1:0]       last;
  logic [WIDTH-1:0] count;

  logic [1:0]       win;
  logic [2:0]       win_oh;
  logic [WIDTH-1:0] win_dur;
  logic             owner_req;

  // Next requester index, modulo 3.
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Round-robin choice: last+1, then last+2, then last itself.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] l);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = next_idx(l);
    c2 = next_idx(c1);
    if (r[c1])      return c1;
    else if (r[c2]) return c2;
    else            return l;
  endfunction

  // Saturating decrement: the countdown never wraps below zero.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
    return (v == ZERO) ? v : v - ONE;
  endfunction

  // Arbitration winner, its duration, and whether the current owner still requests.
  always_comb begin
    win     = rr_pick(req, last);
    win_oh  = 3'b001 << win;
    win_dur = dur0;
    case (win)
      2'd1:    win_dur = dur1;
      2'd2:    win_dur = dur2;
      default: win_dur = dur0;
    endcase
    owner_req = |(req & grant);
  end

  // Controller: load on grant, count ticks, pulse done, or abort on request drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= 3'b000;
      done  <= 3'b000;
      count <= ZERO;
      last  <= 2'd2;
    end else begin
      case (state)
        IDLE: begin
          done <= 3'b000;
          if (|req) begin
            state <= COUNT;
            grant <= win_oh;
            count <= win_dur;
            last  <= win;
          end
        end
        COUNT: begin
          if (!owner_req) begin
            state <= IDLE;
            grant <= 3'b000;
            count <= ZERO;
          end else if (count == ZERO) begin
            state <= DONE;
            done  <= grant;
          end else if (tick_1hz) begin
            count <= sat_dec(count);
          end
        end
        DONE: begin
          state <= IDLE;
          grant <= 3'b000;
          done  <= 3'b000;
          count <= ZERO;
        end
        default: begin
          state <= IDLE;
          grant <= 3'b000;
          done  <= 3'b000;
          count <= ZERO;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign remaining = count;

endmodule

// File: tb/tb_arbitro_temporizador.sv
// Bench for arbitro_temporizador: directed vector table, multi-cycle corner
// sequences, and a long randomized run against a behavioural reference.
module tb_arbitro_temporizador;

  logic       clk;
  logic       reset;
  logic       tick_1hz;
  logic [2:0] req;
  logic [3:0] dur0, dur1, dur2;
  logic [2:0] grant, done;
  logic       busy;
  logic [3:0] remaining;

  int checks = 0;
  int errors = 0;

  arbitro_temporizador #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .req(req),
    .dur0(dur0), .dur1(dur1), .dur2(dur2),
    .grant(grant), .done(done), .busy(busy), .remaining(remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       tick;
    logic [2:0] req;
    logic [3:0] d0, d1, d2;
    logic [2:0] g;
    logic [2:0] dn;
    logic       b;
    logic [3:0] rem;
  } vec_t;

  typedef struct {
    string      name;
    logic [2:0] g;
    logic [2:0] dn;
    logic       b;
    logic [3:0] rem;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  // Reference model state
  int m_st;
  int m_own;
  int m_last;
  int m_cnt;

  task automatic drive(input logic r, input logic t, input logic [2:0] q,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    reset = r; tick_1hz = t; req = q; dur0 = a; dur1 = b; dur2 = c;
  endtask

  task automatic push(input string n, input logic [2:0] g, input logic [2:0] dn,
                      input logic b, input logic [3:0] rem);
    exp_t e;
    e.name = n; e.g = g; e.dn = dn; e.b = b; e.rem = rem;
    sb.push_back(e);
  endtask

  // Advance one edge, then compare DUT outputs with the oldest expectation.
  task automatic step_check();
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got no expectation, required one");
    end else begin
      e = sb.pop_front();
      if (grant !== e.g || done !== e.dn || busy !== e.b || remaining !== e.rem) begin
        errors++;
        $display("FAIL %s: got g=%b d=%b b=%b r=%0d, required g=%b d=%b b=%b r=%0d",
                 e.name, grant, done, busy, remaining, e.g, e.dn, e.b, e.rem);
      end
    end
  endtask

  task automatic seq(input string n, input logic r, input logic t, input logic [2:0] q,
                     input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                     input logic [2:0] g, input logic [2:0] dn, input logic bz,
                     input logic [3:0] rem);
    drive(r, t, q, a, b, c);
    push(n, g, dn, bz, rem);
    step_check();
  endtask

  task automatic add_vec(input logic r, input logic t, input logic [2:0] q,
                         input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic [2:0] g, input logic [2:0] dn, input logic bz,
                         input logic [3:0] rem);
    vec_t v;
    v.rst = r; v.tick = t; v.req = q; v.d0 = a; v.d1 = b; v.d2 = c;
    v.g = g; v.dn = dn; v.b = bz; v.rem = rem;
    tbl.push_back(v);
  endtask

  // Behavioural reference: advance one cycle using the current inputs.
  task automatic model_step(input logic r, input logic t, input logic [2:0] q,
                            input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    int cand;
    int durs[3];
    durs[0] = int'(a); durs[1] = int'(b); durs[2] = int'(c);
    if (r) begin
      m_st = 0; m_cnt = 0; m_last = 2; m_own = 0;
    end else if (m_st == 0) begin
      if (q != 3'b000) begin
        for (int i = 1; i <= 3; i++) begin
          cand = (m_last + i) % 3;
          if (q[cand] && m_st == 0) begin
            m_own = cand; m_last = cand; m_cnt = durs[cand]; m_st = 1;
          end
        end
      end
    end else if (m_st == 1) begin
      if (!q[m_own]) begin
        m_st = 0; m_cnt = 0;
      end else if (m_cnt == 0) begin
        m_st = 2;
      end else if (t) begin
        m_cnt = m_cnt - 1;
      end
    end else begin
      m_st = 0; m_cnt = 0;
    end
  endtask

  initial begin
    logic       r_rst, r_tick;
    logic [2:0] r_req;
    logic [3:0] r_d0, r_d1, r_d2;
    logic [2:0] eg, ed;

    drive(1'b1, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0);

    // Directed table: all requesters, round-robin order, tick at load, abort.
    add_vec(1'b1, 1'b0, 3'b000, 4'd2, 4'd1, 4'd0, 3'b000, 3'b000, 1'b0, 4'd0);
    add_vec(1'b0, 1'b0, 3'b111, 4'd2, 4'd1, 4'd0, 3'b001, 3'b000, 1'b1, 4'd2);
    add_vec(1'b0, 1'b1, 3'b111, 4'd2, 4'd1, 4'd0, 3'b001, 3'b000, 1'b1, 4'd1);
    add_vec(1'b0, 1'b0, 3'b111, 4'd2, 4'd1, 4'd0, 3'b001, 3'b000, 1'b1, 4'd1);
    add_vec(1'b0, 1'b1, 3'b111, 4'd2, 4'd1, 4'd0, 3'b001, 3'b000, 1'b1, 4'd0);
    add_vec(1'b0, 1'b0, 3'b111, 4'd2, 4'd1, 4'd0, 3'b001, 3'b001, 1'b1, 4'd0);
    add_vec(1'b0, 1'b0, 3'b110, 4'd2, 4'd1, 4'd0, 3'b000, 3'b000, 1'b0, 4'd0);
    add_vec(1'b0, 1'b0, 3'b110, 4'd2, 4'd1, 4'd0, 3'b010, 3'b000, 1'b1, 4'd1);
    add_vec(1'b0, 1'b1, 3'b110, 4'd2, 4'd1, 4'd0, 3'b010, 3'b000, 1'b1, 4'd0);
    add_vec(1'b0, 1'b0, 3'b110, 4'd2, 4'd1, 4'd0, 3'b010, 3'b010, 1'b1, 4'd0);
    add_vec(1'b0, 1'b0, 3'b111, 4'd2, 4'd1, 4'd0, 3'b000, 3'b000, 1'b0, 4'd0);
    add_vec(1'b0, 1'b0, 3'b111, 4'd2, 4'd1, 4'd0, 3'b100, 3'b000, 1'b1, 4'd0);
    add_vec(1'b0, 1'b0, 3'b111, 4'd2, 4'd1, 4'd0, 3'b100, 3'b100, 1'b1, 4'd0);
    add_vec(1'b0, 1'b0, 3'b111, 4'd2, 4'd1, 4'd0, 3'b000, 3'b000, 1'b0, 4'd0);
    add_vec(1'b0, 1'b1, 3'b111, 4'd2, 4'd1, 4'd0, 3'b001, 3'b000, 1'b1, 4'd2);
    add_vec(1'b0, 1'b1, 3'b000, 4'd2, 4'd1, 4'd0, 3'b000, 3'b000, 1'b0, 4'd0);
    add_vec(1'b0, 1'b0, 3'b000, 4'd2, 4'd1, 4'd0, 3'b000, 3'b000, 1'b0, 4'd0);

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].tick, tbl[i].req, tbl[i].d0, tbl[i].d1, tbl[i].d2);
      push($sformatf("table_row_%0d", i), tbl[i].g, tbl[i].dn, tbl[i].b, tbl[i].rem);
      step_check();
    end

    // Zero duration: grant at +1, done at +2, idle at +3, no tick needed.
    seq("dur0_reset",   1'b1, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 3'b000, 3'b000, 1'b0, 4'd0);
    seq("dur0_grant",   1'b0, 1'b0, 3'b010, 4'd0, 4'd0, 4'd0, 3'b010, 3'b000, 1'b1, 4'd0);
    seq("dur0_done",    1'b0, 1'b0, 3'b010, 4'd0, 4'd0, 4'd0, 3'b010, 3'b010, 1'b1, 4'd0);
    seq("dur0_release", 1'b0, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 3'b000, 3'b000, 1'b0, 4'd0);

    // Abort after two ticks; dur change mid-count has no effect.
    seq("abort_reset",  1'b1, 1'b0, 3'b000, 4'd0, 4'd0, 4'd5, 3'b000, 3'b000, 1'b0, 4'd0);
    seq("abort_load",   1'b0, 1'b0, 3'b100, 4'd0, 4'd0, 4'd5, 3'b100, 3'b000, 1'b1, 4'd5);
    seq("abort_tick1",  1'b0, 1'b1, 3'b100, 4'd0, 4'd0, 4'd15, 3'b100, 3'b000, 1'b1, 4'd4);
    seq("abort_tick2",  1'b0, 1'b1, 3'b100, 4'd0, 4'd0, 4'd15, 3'b100, 3'b000, 1'b1, 4'd3);
    seq("abort_drop",   1'b0, 1'b0, 3'b000, 4'd0, 4'd0, 4'd15, 3'b000, 3'b000, 1'b0, 4'd0);
    seq("abort_nodone", 1'b0, 1'b1, 3'b000, 4'd0, 4'd0, 4'd15, 3'b000, 3'b000, 1'b0, 4'd0);

    // Tick on load ignored; reset mid-count clears everything with no done.
    seq("midrst_reset", 1'b1, 1'b0, 3'b000, 4'd3, 4'd0, 4'd0, 3'b000, 3'b000, 1'b0, 4'd0);
    seq("midrst_load",  1'b0, 1'b1, 3'b001, 4'd3, 4'd0, 4'd0, 3'b001, 3'b000, 1'b1, 4'd3);
    seq("midrst_hold",  1'b0, 1'b0, 3'b001, 4'd3, 4'd0, 4'd0, 3'b001, 3'b000, 1'b1, 4'd3);
    seq("midrst_apply", 1'b1, 1'b1, 3'b001, 4'd3, 4'd0, 4'd0, 3'b000, 3'b000, 1'b0, 4'd0);
    seq("midrst_after", 1'b0, 1'b0, 3'b000, 4'd3, 4'd0, 4'd0, 3'b000, 3'b000, 1'b0, 4'd0);

    // Randomized run against the reference model, with invariant checks.
    r_req = 3'b000;
    for (int c = 0; c < 10000; c++) begin
      r_rst  = (c == 0) || ($urandom_range(0, 499) == 0);
      r_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) r_req = 3'($urandom_range(0, 7));
      r_d0 = 4'($urandom_range(0, 6));
      r_d1 = 4'($urandom_range(0, 6));
      r_d2 = 4'($urandom_range(0, 6));
      drive(r_rst, r_tick, r_req, r_d0, r_d1, r_d2);
      model_step(r_rst, r_tick, r_req, r_d0, r_d1, r_d2);
      eg = (m_st != 0) ? 3'(1 << m_own) : 3'b000;
      ed = (m_st == 2) ? 3'(1 << m_own) : 3'b000;
      push($sformatf("random_cycle_%0d", c), eg, ed, (m_st != 0), 4'(m_cnt));
      step_check();
      checks++;
      if (!$onehot0(grant) || !$onehot0(done) || busy !== (|grant) ||
          (remaining !== 4'd0 && !busy)) begin
        errors++;
        $display("FAIL invariant_%0d: got g=%b d=%b b=%b r=%0d, required onehot0 g/d, b=|g, r=0 when idle",
                 c, grant, done, busy, remaining);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
